coolgirl_config_regs: RTL and testbench



---
 rtl/coolgirl_cfg_pkg.sv | 84 ++++++++
 rtl/coolgirl_cfg_bank.sv | 42 ++++
 rtl/coolgirl_config_regs.sv | 126 ++++++++++++
 tb/tb_coolgirl_config_regs.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/coolgirl_cfg_pkg.sv
// Shared definitions for the COOLGIRL configuration register block:
// register indices, control bit positions, window decode and the config record.
package coolgirl_cfg_pkg;

    // Register indices within the $5000-$5FFF window (address bits [2:0])
    localparam logic [2:0] REG_BASE_LO      = 3'd0;
    localparam logic [2:0] REG_BASE_HI      = 3'd1;
    localparam logic [2:0] REG_PRG_MASK     = 3'd2;
    localparam logic [2:0] REG_CHR_SRAM     = 3'd3;
    localparam logic [2:0] REG_MAPPER       = 3'd4;
    localparam logic [2:0] REG_FLAGS        = 3'd5;
    localparam logic [2:0] REG_MAPPER_FLAGS = 3'd6;
    localparam logic [2:0] REG_CTRL         = 3'd7;

    // R7 control bit positions
    localparam int unsigned CTRL_COMMIT_BIT = 0;
    localparam int unsigned CTRL_REVERT_BIT = 1;
    localparam int unsigned CTRL_LOCK_BIT   = 7;

    // CPU address bits [14:12] selecting the config window
    localparam logic [2:0] CFG_WINDOW = 3'b101;

    // Configuration record shared by shadow, active and the mapper logic
    typedef struct packed {
        logic [12:0] cpu_base;
        logic [6:0]  prg_mask;
        logic [4:0]  chr_mask;
        logic [1:0]  sram_page;
        logic        sram_enabled;
        logic        prg_write_enabled;
        logic        chr_write_enabled;
        logic        map_rom_on_6000;
        logic        four_screen;
        logic [1:0]  mirroring;
        logic [7:0]  mapper;
        logic [7:0]  mapper_flags;
    } cfg_t;

    // Power-on configuration; the masks and CHR write enable are board-tunable
    function automatic cfg_t cfg_reset_value(
        input logic [6:0] prg_mask,
        input logic [4:0] chr_mask,
        input logic       chr_write
    );
        cfg_t r;
        r                   = '0;
        r.prg_mask          = prg_mask;
        r.chr_mask          = chr_mask;
        r.chr_write_enabled = chr_write;
        return r;
    endfunction

    // Merge one byte-wide register write into a record; R7 and unused bits do nothing
    function automatic cfg_t cfg_write_reg(
        input cfg_t       cur,
        input logic [2:0] idx,
        input logic [7:0] data
    );
        cfg_t r;
        r = cur;
        case (idx)
            REG_BASE_LO:      r.cpu_base[7:0]  = data;
            REG_BASE_HI:      r.cpu_base[12:8] = data[4:0];
            REG_PRG_MASK:     r.prg_mask       = data[6:0];
            REG_CHR_SRAM: begin
                r.chr_mask     = data[4:0];
                r.sram_page    = data[6:5];
                r.sram_enabled = data[7];
            end
            REG_MAPPER:       r.mapper         = data;
            REG_FLAGS: begin
                r.prg_write_enabled = data[0];
                r.chr_write_enabled = data[1];
                r.map_rom_on_6000   = data[2];
                r.four_screen       = data[3];
                r.mirroring         = data[5:4];
            end
            REG_MAPPER_FLAGS: r.mapper_flags   = data;
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/coolgirl_cfg_bank.sv
// One configuration record register: byte-wide register writes plus a
// whole-record load, with load taking priority.
module coolgirl_cfg_bank
    import coolgirl_cfg_pkg::*;
#(
    parameter cfg_t RESET_VAL = '0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic       load_en,
    input  cfg_t       load_val,
    output cfg_t       cfg
);

    cfg_t cfg_d;
    cfg_t cfg_q;

    // Next record: full load wins over a single register write
    always_comb begin
        cfg_d = cfg_q;
        if (load_en) begin
            cfg_d = load_val;
        end else if (wr_en) begin
            cfg_d = cfg_write_reg(cfg_q, wr_idx, wr_data);
        end
    end

    // Record storage with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q <= RESET_VAL;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    assign cfg = cfg_q;

endmodule

// File: rtl/coolgirl_config_regs.sv
// COOLGIRL configuration register block: decodes CPU writes in $5000-$5FFF
// into a shadow record, commits it atomically to the active record, and can
// lock the configuration until reset.
module coolgirl_config_regs
    import coolgirl_cfg_pkg::*;
#(
    parameter logic [6:0] RESET_PRG_MASK  = 7'h7E,
    parameter logic [4:0] RESET_CHR_MASK  = 5'h1F,
    parameter logic       RESET_CHR_WRITE = 1'b1
) (
    input  logic        m2,
    input  logic        reset,
    input  logic        cpu_wr_stb,
    input  logic        romsel,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    output logic [12:0] cpu_base,
    output logic [6:0]  prg_mask,
    output logic [4:0]  chr_mask,
    output logic [1:0]  sram_page,
    output logic        sram_enabled,
    output logic        prg_write_enabled,
    output logic        chr_write_enabled,
    output logic        map_rom_on_6000,
    output logic        four_screen,
    output logic [1:0]  mirroring,
    output logic [7:0]  mapper,
    output logic [7:0]  mapper_flags,
    output logic        commit_pulse,
    output logic        locked
);

    localparam logic STATE_UNLOCKED = 1'b0;
    localparam logic STATE_LOCKED   = 1'b1;

    localparam cfg_t RESET_CFG = cfg_reset_value(RESET_PRG_MASK, RESET_CHR_MASK, RESET_CHR_WRITE);

    logic       state_d, state_q;
    logic       commit_pulse_d, commit_pulse_q;

    logic       cfg_access;
    logic [2:0] reg_idx;
    logic       shadow_wr;
    logic       do_commit;
    logic       do_revert;
    logic       unused_addr_bits;

    cfg_t       shadow_cfg;
    cfg_t       active_cfg;

    // Address bits [11:3] only mirror the eight registers across the window
    assign unused_addr_bits = ^cpu_addr_in[11:3];

    // Access decode; everything is suppressed once locked
    always_comb begin
        cfg_access = cpu_wr_stb & romsel & (cpu_addr_in[14:12] == CFG_WINDOW)
                     & (state_q == STATE_UNLOCKED);
        reg_idx    = cpu_addr_in[2:0];
        shadow_wr  = cfg_access & (reg_idx != REG_CTRL);
        do_commit  = cfg_access & (reg_idx == REG_CTRL) & cpu_data_in[CTRL_COMMIT_BIT];
        do_revert  = cfg_access & (reg_idx == REG_CTRL) & cpu_data_in[CTRL_REVERT_BIT]
                     & ~cpu_data_in[CTRL_COMMIT_BIT];
    end

    // Lock FSM and commit pulse next-state
    always_comb begin
        state_d        = state_q;
        commit_pulse_d = do_commit;
        if (do_commit && cpu_data_in[CTRL_LOCK_BIT]) begin
            state_d = STATE_LOCKED;
        end
    end

    // Lock state and commit pulse registers
    always_ff @(posedge m2) begin
        if (reset) begin
            state_q        <= STATE_UNLOCKED;
            commit_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            commit_pulse_q <= commit_pulse_d;
        end
    end

    coolgirl_cfg_bank #(
        .RESET_VAL (RESET_CFG)
    ) u_shadow (
        .clk      (m2),
        .reset    (reset),
        .wr_en    (shadow_wr),
        .wr_idx   (reg_idx),
        .wr_data  (cpu_data_in),
        .load_en  (do_revert),
        .load_val (active_cfg),
        .cfg      (shadow_cfg)
    );

    coolgirl_cfg_bank #(
        .RESET_VAL (RESET_CFG)
    ) u_active (
        .clk      (m2),
        .reset    (reset),
        .wr_en    (1'b0),
        .wr_idx   ('0),
        .wr_data  ('0),
        .load_en  (do_commit),
        .load_val (shadow_cfg),
        .cfg      (active_cfg)
    );

    assign cpu_base          = active_cfg.cpu_base;
    assign prg_mask          = active_cfg.prg_mask;
    assign chr_mask          = active_cfg.chr_mask;
    assign sram_page         = active_cfg.sram_page;
    assign sram_enabled      = active_cfg.sram_enabled;
    assign prg_write_enabled = active_cfg.prg_write_enabled;
    assign chr_write_enabled = active_cfg.chr_write_enabled;
    assign map_rom_on_6000   = active_cfg.map_rom_on_6000;
    assign four_screen       = active_cfg.four_screen;
    assign mirroring         = active_cfg.mirroring;
    assign mapper            = active_cfg.mapper;
    assign mapper_flags      = active_cfg.mapper_flags;
    assign commit_pulse      = commit_pulse_q;
    assign locked            = (state_q == STATE_LOCKED);

endmodule

// File: tb/tb_coolgirl_config_regs.sv
// Directed table-driven bench for coolgirl_config_regs.
module tb_coolgirl_config_regs;

    logic        m2;
    logic        reset;
    logic        cpu_wr_stb;
    logic        romsel;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic [12:0] cpu_base;
    logic [6:0]  prg_mask;
    logic [4:0]  chr_mask;
    logic [1:0]  sram_page;
    logic        sram_enabled;
    logic        prg_write_enabled;
    logic        chr_write_enabled;
    logic        map_rom_on_6000;
    logic        four_screen;
    logic [1:0]  mirroring;
    logic [7:0]  mapper;
    logic [7:0]  mapper_flags;
    logic        commit_pulse;
    logic        locked;

    // Outputs grouped as the register bytes they come from
    typedef struct packed {
        logic [12:0] base;
        logic [6:0]  prg;
        logic [7:0]  r3;
        logic [7:0]  map;
        logic [7:0]  r5;
        logic [7:0]  flg;
        logic        pulse;
        logic        lock;
    } obs_t;

    typedef struct {
        logic        stb;
        logic        rs;
        logic [14:0] addr;
        logic [7:0]  data;
        obs_t        exp;
    } vec_t;

    localparam int unsigned NVEC = 23;
    vec_t vecs [NVEC];

    int tests_run = 0;
    int tests_failed = 0;

    coolgirl_config_regs #(
        .RESET_PRG_MASK  (7'h7E),
        .RESET_CHR_MASK  (5'h1F),
        .RESET_CHR_WRITE (1'b1)
    ) dut (
        .m2                (m2),
        .reset             (reset),
        .cpu_wr_stb        (cpu_wr_stb),
        .romsel            (romsel),
        .cpu_addr_in       (cpu_addr_in),
        .cpu_data_in       (cpu_data_in),
        .cpu_base          (cpu_base),
        .prg_mask          (prg_mask),
        .chr_mask          (chr_mask),
        .sram_page         (sram_page),
        .sram_enabled      (sram_enabled),
        .prg_write_enabled (prg_write_enabled),
        .chr_write_enabled (chr_write_enabled),
        .map_rom_on_6000   (map_rom_on_6000),
        .four_screen       (four_screen),
        .mirroring         (mirroring),
        .mapper            (mapper),
        .mapper_flags      (mapper_flags),
        .commit_pulse      (commit_pulse),
        .locked            (locked)
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    function automatic obs_t mk_obs(input logic [12:0] base, input logic [6:0] prg,
                                    input logic [7:0] r3, input logic [7:0] map,
                                    input logic [7:0] r5, input logic [7:0] flg,
                                    input logic pulse, input logic lock);
        obs_t o;
        o.base = base; o.prg = prg; o.r3 = r3; o.map = map;
        o.r5 = r5; o.flg = flg; o.pulse = pulse; o.lock = lock;
        return o;
    endfunction

    function automatic vec_t mk_vec(input logic stb, input logic rs, input logic [14:0] addr,
                                    input logic [7:0] data, input obs_t exp);
        vec_t v;
        v.stb = stb; v.rs = rs; v.addr = addr; v.data = data; v.exp = exp;
        return v;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.base  = cpu_base;
        o.prg   = prg_mask;
        o.r3    = {sram_enabled, sram_page, chr_mask};
        o.map   = mapper;
        o.r5    = {2'b00, mirroring, four_screen, map_rom_on_6000, chr_write_enabled, prg_write_enabled};
        o.flg   = mapper_flags;
        o.pulse = commit_pulse;
        o.lock  = locked;
        return o;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t got;
        got = sample();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got base=%h prg=%h r3=%h map=%h r5=%h flg=%h pulse=%b lock=%b, want base=%h prg=%h r3=%h map=%h r5=%h flg=%h pulse=%b lock=%b",
                     name, got.base, got.prg, got.r3, got.map, got.r5, got.flg, got.pulse, got.lock,
                     exp.base, exp.prg, exp.r3, exp.map, exp.r5, exp.flg, exp.pulse, exp.lock);
        end
    endtask

    // One strobe cycle, then a check 1 time unit after the capturing edge
    task automatic apply(input logic stb, input logic rs, input logic [14:0] addr, input logic [7:0] data);
        cpu_wr_stb  = stb;
        romsel      = rs;
        cpu_addr_in = addr;
        cpu_data_in = data;
        @(posedge m2);
        #1;
        cpu_wr_stb  = 1'b0;
    endtask

    obs_t RST;
    obs_t A;   // after first commit
    obs_t B;   // after prg_mask commit
    obs_t C;   // after commit-wins flags commit
    obs_t L;   // locked configuration

    initial begin
        RST = mk_obs(13'h0000, 7'h7E, 8'h1F, 8'h00, 8'h02, 8'h00, 1'b0, 1'b0);
        A   = mk_obs(13'h1234, 7'h7E, 8'h1F, 8'h04, 8'h02, 8'h00, 1'b0, 1'b0);
        B   = mk_obs(13'h1234, 7'h55, 8'h1F, 8'h04, 8'h02, 8'h00, 1'b0, 1'b0);
        C   = mk_obs(13'h1234, 7'h55, 8'h1F, 8'h04, 8'h0F, 8'h00, 1'b0, 1'b0);
        L   = mk_obs(13'h1234, 7'h55, 8'hE5, 8'h04, 8'h30, 8'hA5, 1'b0, 1'b1);

        vecs[0]  = mk_vec(1, 1, 15'h5000, 8'h34, RST);
        vecs[1]  = mk_vec(1, 1, 15'h5001, 8'h12, RST);
        vecs[2]  = mk_vec(1, 1, 15'h5004, 8'h04, RST);
        vecs[3]  = mk_vec(1, 1, 15'h5007, 8'h01, mk_obs(13'h1234, 7'h7E, 8'h1F, 8'h04, 8'h02, 8'h00, 1'b1, 1'b0));
        vecs[4]  = mk_vec(0, 1, 15'h5007, 8'h01, A);
        vecs[5]  = mk_vec(1, 1, 15'h5FFA, 8'h55, A);
        vecs[6]  = mk_vec(1, 1, 15'h4002, 8'h11, A);
        vecs[7]  = mk_vec(1, 1, 15'h6002, 8'h22, A);
        vecs[8]  = mk_vec(1, 0, 15'h5002, 8'h33, A);
        vecs[9]  = mk_vec(1, 1, 15'h5007, 8'h01, mk_obs(13'h1234, 7'h55, 8'h1F, 8'h04, 8'h02, 8'h00, 1'b1, 1'b0));
        vecs[10] = mk_vec(1, 1, 15'h5005, 8'h0F, B);
        vecs[11] = mk_vec(1, 1, 15'h5007, 8'h02, B);
        vecs[12] = mk_vec(1, 1, 15'h5007, 8'h01, mk_obs(13'h1234, 7'h55, 8'h1F, 8'h04, 8'h02, 8'h00, 1'b1, 1'b0));
        vecs[13] = mk_vec(1, 1, 15'h5005, 8'h0F, B);
        vecs[14] = mk_vec(1, 1, 15'h5007, 8'h03, mk_obs(13'h1234, 7'h55, 8'h1F, 8'h04, 8'h0F, 8'h00, 1'b1, 1'b0));
        vecs[15] = mk_vec(1, 1, 15'h5003, 8'hE5, C);
        vecs[16] = mk_vec(1, 1, 15'h5006, 8'hA5, C);
        vecs[17] = mk_vec(1, 1, 15'h5005, 8'hF0, C);
        vecs[18] = mk_vec(1, 1, 15'h5007, 8'h80, C);
        vecs[19] = mk_vec(1, 1, 15'h5007, 8'h81, mk_obs(13'h1234, 7'h55, 8'hE5, 8'h04, 8'h30, 8'hA5, 1'b1, 1'b1));
        vecs[20] = mk_vec(1, 1, 15'h5004, 8'hFF, L);
        vecs[21] = mk_vec(1, 1, 15'h5007, 8'h01, L);
        vecs[22] = mk_vec(1, 1, 15'h5007, 8'h02, L);

        reset       = 1'b1;
        cpu_wr_stb  = 1'b0;
        romsel      = 1'b0;
        cpu_addr_in = '0;
        cpu_data_in = '0;
        repeat (2) @(posedge m2);
        #1;
        reset = 1'b0;
        check("reset_state", RST);

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].stb, vecs[i].rs, vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset releases the lock and restores the power-on configuration
        reset = 1'b1;
        apply(0, 1, 15'h5000, 8'h00);
        reset = 1'b0;
        check("reset_unlock", RST);

        // Partial shadow write, then reset coinciding with a commit+lock strobe
        apply(1, 1, 15'h5000, 8'hAA);
        check("partial_shadow", RST);
        reset = 1'b1;
        apply(1, 1, 15'h5007, 8'h81);
        reset = 1'b0;
        check("reset_beats_strobe", RST);
        apply(0, 1, 15'h5000, 8'h00);
        check("reset_beats_strobe_idle", RST);

        // Shadow must have returned to reset values: a commit changes nothing but pulses
        apply(1, 1, 15'h5007, 8'h01);
        check("commit_after_reset", mk_obs(13'h0000, 7'h7E, 8'h1F, 8'h00, 8'h02, 8'h00, 1'b1, 1'b0));
        apply(0, 1, 15'h5000, 8'h00);
        check("pulse_drops", RST);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
